uart_tx_model: RTL and testbench
================================

# uart_tx_model

Testbench-side UART transmitter for the CEP co-simulation environment. It accepts bytes over a valid/ready interface, typically driven from a v2c command handler, and buffers them in a small FIFO. It then serializes them as standard async frames (start bit, LSB-first payload, stop bits) onto a line that drives the DUT's UART receive pin. It is the send-side counterpart of the bench's UART line-logging receiver, and the two are used together for loopback self-checks.

## Interface
- `BIT_RATE`, 9600, line bit rate in bits/s
- `CLK_HZ`, 50_000_000, frequency of `clk` in Hz
- `PAYLOAD_BITS`, 8, data bits per frame (5..8)
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `FIFO_DEPTH`, 16, byte FIFO entries (power of 2, >=2)

- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high reset.
- `tx_en` in 1: when low, no new frame starts; a frame already in flight completes.
- `in_valid` in 1: `in_data` valid.
- `in_data` in PAYLOAD_BITS: byte to send.
- `in_ready` out 1: FIFO not full; a push occurs on any edge where `in_valid && in_ready`.
- `uart_txd` out 1: serial line, idle high, registered.
- `busy` out 1: a frame is in flight (FSM not IDLE), registered.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, integer truncation. Elaboration error if the result is < 2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty and `tx_en`=1, pop into a shift register, clear the bit counter, go to START.
  - START: `uart_txd`=0 for CYCLES_PER_BIT cycles, then DATA.
  - DATA: send shift[0] for CYCLES_PER_BIT cycles, shift right, repeat PAYLOAD_BITS times, then STOP.
  - STOP: `uart_txd`=1 for STOP_BITS×CYCLES_PER_BIT cycles. On the last cycle, if the FIFO is non-empty and `tx_en`=1, pop and go directly to START with zero idle gap. Otherwise go to IDLE.
- Counters:
  - Cycle counter: width $clog2(STOP_BITS×CYCLES_PER_BIT), cleared on every state change.
  - Bit index: width $clog2(PAYLOAD_BITS).
- FIFO:
  - `in_ready = (fifo_count != FIFO_DEPTH)`, derived from registered state only.
  - A pop in the same cycle does not raise `in_ready`.
  - Simultaneous push and pop when non-empty and not full leaves `fifo_count` unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped on the next edge at the earliest.
- Pointer wrap: pointers are modulo FIFO_DEPTH. `fifo_count` carries the full/empty distinction.
- Dropping `tx_en` mid-frame has no effect until the frame ends; the FSM then parks in IDLE with the FIFO retained.
- Reset, including mid-frame: on the next edge `uart_txd`=1, `busy`=0, `fifo_count`=0, state IDLE, the FIFO is flushed, and `in_ready`=1. A truncated frame is not resumed.

## Timing
- Reset values: `uart_txd`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
- Push accepted at edge N → `fifo_count` increments after N. Pop occurs at edge N+1, and `uart_txd` falls at edge N+1 (start bit visible in cycle N+1).
- Frame duration is (1+PAYLOAD_BITS+STOP_BITS)×CYCLES_PER_BIT cycles.
- `busy` rises with the start bit. It falls one cycle after the last stop-bit cycle, and only if nothing follows.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle.

## Structure
- Shared package `uart_model_pkg` holds:
  - the `uart_tx_state_e` typedef (IDLE/START/DATA/STOP);
  - the function `cycles_per_bit(clk_hz, bit_rate)`, also used by the receiver model.
- Sub-module `uart_tx_fifo` is a synchronous FIFO with parameters width/depth, push/pop ports, and a count output.
- The top module contains the FSM, counters and shift register only.

## Test plan
- Use CLK_HZ=1_000_000 and BIT_RATE=100_000 (CYCLES_PER_BIT=10) throughout unless stated otherwise.
- Single byte 0x41 → start low 10 cycles; then bits 1,0,0,0,0,0,1,0 at 10 cycles each; then stop high 10 cycles. Start falls 1 cycle after accept, and `busy` is high for exactly 100 cycles.
- Bytes 0x55,0xAA,0x0A pushed on consecutive cycles → 300 contiguous frame cycles with no idle high gap, and `fifo_count` sequence 1,2,3 then decrementing at each pop.
- `tx_en`=0, push 17 bytes → `in_ready` drops after the 16th push and `fifo_count`=16, with `uart_txd` held at 1. Raising `tx_en` drains all 16 frames in 1600 cycles.
- `reset` asserted at cycle 35 of a frame with 3 bytes queued → next edge: `uart_txd`=1, `fifo_count`=0, `busy`=0, and no further transitions on the line.
- STOP_BITS=2 with bytes 0x00,0xFF → frames 110 cycles each, and the stop high period lasts 20 cycles before the second start bit.
- Loopback: `uart_txd` → bench UART receiver model, send "Hi\n" → receiver logs `TB_UART: Hi`.

Source files
------------

// File: rtl/uart_model_pkg.sv
// -----------------------------------------------------------------------------
// uart_model_pkg
// Shared definitions for the bench-side UART models (transmitter and the
// line-logging receiver): the transmitter FSM state type and the bit-period
// helper used by both models so they agree on line timing.
// -----------------------------------------------------------------------------
package uart_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // Clock cycles per line bit, truncated toward zero.
  function automatic int cycles_per_bit(input longint clk_hz, input longint bit_rate);
    return int'(clk_hz / bit_rate);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO feeding the UART transmitter. Read data is the head
// entry, combinationally available; a pop consumes it on the clock edge.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes the FIFO)
//   push        : write push_data at the tail (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : current head entry
//   count       : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_model_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap naturally at the power-of-two depth; count_q alone tells
  // full from empty when the pointers are equal.
  always_comb begin
    do_push  = push && (count_q != FULL);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_model.sv
// -----------------------------------------------------------------------------
// uart_tx_model
// Bench-side UART transmitter. Bytes arrive over valid/ready, are queued in a
// small FIFO and sent as async frames: one start bit (0), PAYLOAD_BITS data
// bits LSB first, STOP_BITS stop bits (1). Back-to-back frames have no gap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (aborts any frame)
//   tx_en       : gate for starting new frames; a frame in flight completes
//   in_valid    : in_data is valid; pushed when in_valid && in_ready
//   in_data     : byte to send
//   in_ready    : FIFO not full (registered state only)
//   uart_txd    : serial line, idle high, registered
//   busy        : frame in flight, registered
//   fifo_count  : FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_model
  import uart_model_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic                          in_valid,
  input  logic [PAYLOAD_BITS-1:0]       in_data,
  output logic                          in_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CYC_W    = $clog2(STOP_CYC);
  localparam int BIT_W    = $clog2(PAYLOAD_BITS);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(CPB - 1);
  localparam logic [CYC_W-1:0] STOP_LAST = CYC_W'(STOP_CYC - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  if (CPB < 2) begin : g_bad_rate
    $error("uart_tx_model: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
    $error("uart_tx_model: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_model: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_model: FIFO_DEPTH must be a power of 2, >= 2");
  end

  uart_tx_state_e            state_q, state_d;
  logic [CYC_W-1:0]          cyc_q, cyc_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0]   shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;

  logic                      push, pop, start_ok;
  logic [PAYLOAD_BITS-1:0]   pop_data;

  assign in_ready = (fifo_count != FIFO_FULL);
  assign push     = in_valid && in_ready;
  // fifo_count is registered, so a byte pushed into an empty FIFO is only
  // seen here one edge later: there is no bypass path.
  assign start_ok = (fifo_count != '0) && tx_en;

  uart_tx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count)
  );

  // uart_txd is registered, so every transition computes the line level for
  // the first cycle of the next state rather than the current one.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CYC_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = pop_data;
          bit_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            txd_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (cyc_q == STOP_LAST) begin
          cyc_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (start_ok) begin
            pop     = 1'b1;
            shift_d = pop_data;
            bit_d   = '0;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cyc_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // Payload shifter holds data only; it is reloaded before every frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_model.sv
`timescale 1ns/1ps
module tb_uart_tx_model;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en, in_valid;
  logic [7:0] in_data;
  logic       in_ready, uart_txd, busy;
  logic [4:0] fifo_count;

  logic       tx_en2, in_valid2;
  logic [7:0] in_data2;
  logic       in_ready2, uart_txd2, busy2;
  logic [4:0] fifo_count2;

  always #5 clk = ~clk;

  uart_tx_model #(
    .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .uart_txd(uart_txd),
    .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_model #(
    .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut2 (
    .clk(clk), .reset(reset), .tx_en(tx_en2), .in_valid(in_valid2),
    .in_data(in_data2), .in_ready(in_ready2), .uart_txd(uart_txd2),
    .busy(busy2), .fifo_count(fifo_count2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Line receiver model: samples mid-bit at 10 cycles per bit, logs text lines.
  logic [7:0] rx_q[$];
  string      rx_line = "";
  string      last_log = "";

  always begin : rx_model
    logic [7:0] b;
    @(negedge uart_txd);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b[i] = uart_txd;
      if (i < 7) repeat (10) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    if (uart_txd === 1'b1) begin
      rx_q.push_back(b);
      if (b == 8'h0A) begin
        last_log = {"TB_UART: ", rx_line};
        $display("%s", last_log);
        rx_line = "";
      end else if (b >= 8'h20 && b < 8'h7F) begin
        rx_line = $sformatf("%s%c", rx_line, b);
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit k = line level during bit period k (0 = start)
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         errs, nbusy, n, run;
    logic       exp_l;
    logic [4:0] c100, c200;
    logic [9:0] f1 [3];
    logic [10:0] f2 [2];
    logic       line2 [230];
    logic       all_hi;

    vecs[0] = '{8'h41, 10'b1_01000001_0};
    vecs[1] = '{8'h55, 10'b1_01010101_0};
    vecs[2] = '{8'hAA, 10'b1_10101010_0};
    vecs[3] = '{8'h00, 10'b1_00000000_0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0};
    vecs[5] = '{8'h3C, 10'b1_00111100_0};
    f1[0] = 10'b1_01010101_0;
    f1[1] = 10'b1_10101010_0;
    f1[2] = 10'b1_00001010_0;
    f2[0] = 11'b11_00000000_0;
    f2[1] = 11'b11_11111111_0;

    reset = 1'b1; tx_en = 1'b1; in_valid = 1'b0; in_data = '0;
    tx_en2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      in_valid = 1'b1; in_data = vecs[v].data;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_accept_count", v), fifo_count, 1);
      check($sformatf("v%0d_pre_start_txd", v), uart_txd, 1);
      @(negedge clk);
      check($sformatf("v%0d_popped_count", v), fifo_count, 0);
      errs = 0; nbusy = 0;
      for (int t = 0; t < 110; t++) begin
        exp_l = (t < 100) ? vecs[v].frame[t / 10] : 1'b1;
        if (uart_txd !== exp_l) errs++;
        if (busy === 1'b1) nbusy++;
        @(negedge clk);
      end
      check($sformatf("v%0d_wave_errs", v), errs, 0);
      check($sformatf("v%0d_busy_len", v), nbusy, 100);
      check($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // Three queued bytes, then contiguous frames.
    tx_en = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("seq_count1", fifo_count, 1);
    in_data = 8'hAA;
    @(negedge clk);
    check("seq_count2", fifo_count, 2);
    in_data = 8'h0A;
    @(negedge clk);
    check("seq_count3", fifo_count, 3);
    in_valid = 1'b0; tx_en = 1'b1;
    @(negedge clk);
    check("seq_count_pop1", fifo_count, 2);
    errs = 0; nbusy = 0; c100 = '0; c200 = '0;
    for (int t = 0; t < 310; t++) begin
      exp_l = (t < 300) ? f1[t / 100][(t % 100) / 10] : 1'b1;
      if (uart_txd !== exp_l) errs++;
      if (busy === 1'b1) nbusy++;
      if (t == 100) c100 = fifo_count;
      if (t == 200) c200 = fifo_count;
      @(negedge clk);
    end
    check("seq_wave_errs", errs, 0);
    check("seq_busy_len", nbusy, 300);
    check("seq_count_pop2", c100, 1);
    check("seq_count_pop3", c200, 0);

    // FIFO fill with tx_en low, then drain.
    tx_en = 1'b0; all_hi = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      @(negedge clk);
      all_hi = all_hi & (uart_txd === 1'b1);
      if (i < 16) check($sformatf("fill%0d_ready_count", i), {in_ready, fifo_count},
                        {((i + 1) != 16), 5'(i + 1)});
      else check("fill16_ready_count", {in_ready, fifo_count}, {1'b0, 5'd16});
    end
    check("fill_line_idle", all_hi, 1);
    in_valid = 1'b0; tx_en = 1'b1;
    rx_q.delete();
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("drain_busy_len", n, 1600);
    check("drain_count", fifo_count, 0);
    check("drain_rx_size", rx_q.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < rx_q.size()) check($sformatf("drain_rx%0d", k), rx_q[k], 8'h30 + 8'(k));
      else check($sformatf("drain_rx%0d_missing", k), 0, 1);

    // Reset in mid-frame with bytes queued.
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h11 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0; tx_en = 1'b1;
    @(negedge clk);
    repeat (35) @(negedge clk);
    check("mid_pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    errs = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("mid_rst_quiet", errs, 0);
    rx_q.delete(); rx_line = ""; last_log = "";

    // Two stop bits on the second instance.
    in_valid2 = 1'b1; in_data2 = 8'h00;
    @(negedge clk);
    in_data2 = 8'hFF;
    @(negedge clk);
    in_valid2 = 1'b0; tx_en2 = 1'b1;
    @(negedge clk);
    errs = 0; nbusy = 0;
    for (int t = 0; t < 230; t++) begin
      line2[t] = uart_txd2;
      exp_l = (t < 220) ? f2[t / 110][(t % 110) / 10] : 1'b1;
      if (uart_txd2 !== exp_l) errs++;
      if (busy2 === 1'b1) nbusy++;
      @(negedge clk);
    end
    run = 0;
    for (int t = 109; t >= 0 && line2[t] === 1'b1; t--) run++;
    check("stop2_wave_errs", errs, 0);
    check("stop2_busy_len", nbusy, 220);
    check("stop2_stop_run", run, 20);
    check("stop2_second_start", line2[110], 0);

    // Loopback text through the receiver model.
    in_valid = 1'b1; in_data = "H";
    @(negedge clk);
    in_data = "i";
    @(negedge clk);
    in_data = 8'h0A;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (last_log == "" && n < 500) begin
      n++;
      @(negedge clk);
    end
    n_total++;
    if (last_log == "TB_UART: Hi") n_pass++;
    else $display("FAIL loopback_log: got '%s', expected 'TB_UART: Hi'", last_log);
    check("loopback_rx_size", rx_q.size(), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
